// File: rtl/pwm_pkg.sv
// pwm_pkg: default timing constants and the duty clamp helper shared by pwm_multi.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package pwm_pkg;

  // Defaults sized for 50 Hz servo frames from a 50 MHz clock.
  localparam int unsigned DEF_PERIOD   = 1_000_000;
  localparam int unsigned DEF_STEP     = 5_000;
  localparam int unsigned DEF_DC_MIN   = 5_000;
  localparam int unsigned DEF_DC_MAX   = 150_000;
  localparam int unsigned DEF_DC_RESET = 25_000;

  // Clamp v into [lo, hi]; 64-bit operands so any duty width up to 63 bits fits.
  function automatic logic [63:0] clamp(input logic [63:0] v,
                                        input logic [63:0] lo,
                                        input logic [63:0] hi);
    if (v < lo)
      return lo;
    else if (v > hi)
      return hi;
    else
      return v;
  endfunction

endpackage

// File: rtl/pwm_duty_reg.sv
// pwm_duty_reg: one channel's pending duty (load/inc/dec with saturation) and active duty.
// Latency: pending updates next cycle; active follows pending on the commit cycle.
// Backpressure: none; every strobe is consumed in the cycle it is high.
module pwm_duty_reg
  import pwm_pkg::*;
#(
  parameter int          CW       = 32,
  parameter int unsigned STEP     = DEF_STEP,
  parameter int unsigned DC_MIN   = DEF_DC_MIN,
  parameter int unsigned DC_MAX   = DEF_DC_MAX,
  parameter int unsigned DC_RESET = DEF_DC_RESET
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  input  logic          ld,
  input  logic [CW-1:0] ld_duty,
  input  logic          commit,
  output logic [CW-1:0] active
);

  // One extra bit on the saturation arithmetic so pending+STEP can never wrap.
  localparam logic [CW:0]   STEP_W = (CW+1)'(STEP);
  localparam logic [CW:0]   MIN_W  = (CW+1)'(DC_MIN);
  localparam logic [CW:0]   MAX_W  = (CW+1)'(DC_MAX);
  localparam logic [CW-1:0] RST_V  = CW'(DC_RESET);

  logic [CW-1:0] pending;
  logic [CW-1:0] pending_nxt;
  logic [CW:0]   up_sum;

  assign up_sum = {1'b0, pending} + STEP_W;

  // Next pending duty: load beats strobes, inc+dec together cancel.
  always_comb begin
    pending_nxt = pending;
    if (ld)
      pending_nxt = CW'(clamp(64'(ld_duty), 64'(DC_MIN), 64'(DC_MAX)));
    else if (inc && !dec)
      pending_nxt = (up_sum > MAX_W) ? MAX_W[CW-1:0] : up_sum[CW-1:0];
    else if (dec && !inc)
      pending_nxt = ({1'b0, pending} < (MIN_W + STEP_W)) ? MIN_W[CW-1:0]
                                                         : pending - STEP_W[CW-1:0];
  end

  // Pending tracks every update; active only moves at the period boundary,
  // taking the same-cycle update too so nothing arriving on the last cycle is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= RST_V;
      active  <= RST_V;
    end else begin
      pending <= pending_nxt;
      if (commit)
        active <= pending_nxt;
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: CH-channel PWM on a shared period counter with glitch-free duty updates.
// Latency: counter to pin 1 cycle; duty changes land at the next period boundary.
// Backpressure: none. Define PWM_CENTER_ALIGN_EN for a centre-aligned triangle counter.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int          CH       = 4,
  parameter int          CW       = 32,
  parameter int unsigned PERIOD   = DEF_PERIOD,
  parameter int unsigned STEP     = DEF_STEP,
  parameter int unsigned DC_MIN   = DEF_DC_MIN,
  parameter int unsigned DC_MAX   = DEF_DC_MAX,
  parameter int unsigned DC_RESET = DEF_DC_RESET
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [CH-1:0]                       inc,
  input  logic [CH-1:0]                       dec,
  input  logic                                ld_valid,
  input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] ld_ch,
  input  logic [CW-1:0]                       ld_duty,
  output logic [CH-1:0]                       pwm_out,
  output logic                                period_start,
  output logic [CH*CW-1:0]                    duty_o
);

  localparam int          CHW  = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt;
  logic          commit;
  logic          at_start;
  logic [CW-1:0] active [CH];

`ifdef PWM_CENTER_ALIGN_EN
  logic down;

  // The valley is reached while counting down; reset parks the counter there
  // so the very first cycle after release commits and flags a period start.
  assign commit   = (cnt == '0) && down;
  assign at_start = commit;

  // Triangle counter 0 -> PERIOD-1 -> 0, turning around at each end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      down <= 1'b1;
    end else if (down) begin
      if (cnt == '0) begin
        down <= 1'b0;
        cnt  <= cnt + CW'(1);
      end else begin
        cnt  <= cnt - CW'(1);
      end
    end else begin
      if (cnt == LAST) begin
        down <= 1'b1;
        cnt  <= cnt - CW'(1);
      end else begin
        cnt  <= cnt + CW'(1);
      end
    end
  end
`else
  assign commit   = (cnt == LAST);
  assign at_start = (cnt == '0);

  // Sawtooth counter 0..PERIOD-1, wrapping to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (commit)
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end
`endif

  // Per-channel duty registers; a load addressed past CH-1 matches no channel.
  for (genvar i = 0; i < CH; i++) begin : g_ch
    pwm_duty_reg #(
      .CW       (CW),
      .STEP     (STEP),
      .DC_MIN   (DC_MIN),
      .DC_MAX   (DC_MAX),
      .DC_RESET (DC_RESET)
    ) u_duty (
      .clk     (clk),
      .rst     (rst),
      .inc     (inc[i]),
      .dec     (dec[i]),
      .ld      (ld_valid && (ld_ch == CHW'(i))),
      .ld_duty (ld_duty),
      .commit  (commit),
      .active  (active[i])
    );

    assign duty_o[i*CW +: CW] = active[i];
  end

  // Registered pin compare and period marker, one cycle behind the counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_out      <= '0;
      period_start <= 1'b0;
    end else begin
      for (int i = 0; i < CH; i++)
        pwm_out[i] <= (cnt < active[i]);
      period_start <= at_start;
    end
  end

endmodule
